// File: rtl/demo_all_wb_master.sv
// Wishbone classic initiator for the demo_all register map: one local command -> one bus cycle -> one response.
// Optional write readback check is enabled by defining DEMO_ALL_WB_MASTER_VERIFY_EN.
module demo_all_wb_master #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int MAP_SIZE = 8448,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_err_o,
  output logic              rsp_tmo_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [3:0]        wb_sel_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  input  logic              wb_stall_i,
  output logic [2:0]        dbg_state_o
);

  // cmd and rsp are valid/ready ports: a transfer happens on a rising clk_i edge
  // where valid and ready are both high; rsp payload is held stable while rsp_valid_o is high.
  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_BUS,
    S_RESP
`ifdef DEMO_ALL_WB_MASTER_VERIFY_EN
    , S_VERIFY
`endif
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              stb_q, stb_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_tmo_q, rsp_tmo_d;
  logic              bus_active;

`ifdef DEMO_ALL_WB_MASTER_VERIFY_EN
  assign bus_active = (state_q == S_BUS) || (state_q == S_VERIFY);
`else
  assign bus_active = (state_q == S_BUS);
`endif

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    data_d     = data_q;
    stb_d      = stb_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    rsp_tmo_d  = rsp_tmo_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          we_d    = cmd_we_i;
          addr_d  = cmd_addr_i;
          data_d  = cmd_data_i;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if ((addr_q[1:0] != 2'b00) || (32'(addr_q) >= MAP_SIZE)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          rsp_tmo_d  = 1'b0;
          state_d    = S_RESP;
        end else begin
          stb_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_BUS;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          rsp_tmo_d  = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        // Bus phase (write/read, and the readback when enabled); err outranks ack, ack outranks timeout.
        if (wb_err_i) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          rsp_tmo_d  = 1'b0;
          state_d    = S_RESP;
        end else if (wb_ack_i) begin
          rsp_data_d = we_q ? '0 : wb_dat_i;
          rsp_err_d  = 1'b0;
          rsp_tmo_d  = 1'b0;
          state_d    = S_RESP;
`ifdef DEMO_ALL_WB_MASTER_VERIFY_EN
          if (state_q == S_VERIFY) begin
            rsp_data_d = wb_dat_i;
            rsp_err_d  = (wb_dat_i != data_q);
          end else if (we_q) begin
            stb_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_VERIFY;
          end
`endif
        end else if (cnt_q == TMO_LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          rsp_tmo_d  = 1'b1;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (!wb_stall_i) stb_d = 1'b0;
        end
      end
    endcase
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      stb_q       <= 1'b0;
      cnt_q       <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      stb_q       <= stb_d;
      cnt_q       <= cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tmo_q   <= rsp_tmo_d;
    end
  end

  // Bus outputs decode from state so an async reset drops cyc/stb immediately.
  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_tmo_o   = rsp_tmo_q;
  assign wb_cyc_o    = bus_active;
  assign wb_stb_o    = bus_active && stb_q;
  assign wb_we_o     = (state_q == S_BUS) && we_q;
  assign wb_adr_o    = {addr_q[ADDR_W-1:2], 2'b00};
  assign wb_sel_o    = 4'hF;
  assign wb_dat_o    = data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_demo_all_wb_master.sv
// Scoreboard bench for demo_all_wb_master: behavioural Wishbone slave, queue-based response checking.
`timescale 1ns/1ps
module tb_demo_all_wb_master;

  localparam int M_OK = 0, M_ERR = 1, M_NOACK = 2, M_BOTH = 3, M_BADRB = 4;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [13:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_tmo;
  logic [31:0] rsp_data;
  logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err, wb_stall;
  logic [13:0] wb_adr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_o, wb_dat_i;
  logic [2:0]  dbg_state;

  int          s_mode, s_stall, s_delay, s_k;
  logic        s_resp;
  logic [31:0] rb_val;
  logic [31:0] s_mem     [0:4095];
  logic [31:0] model_mem [0:4095];
  logic [33:0] exp_q[$];

  int n_checks, n_errs;
  int cyc_no, cyc_cnt, stb_cnt, rd_stb_cnt, rsp_cnt, issued, rise_cyc, acc_cyc;
  int base_cyc, base_stb, base_rd;
  logic [13:0] cur_addr;
  logic [31:0] cur_data;
  logic        cur_we, prev_rv;

  demo_all_wb_master dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_err_o(rsp_err), .rsp_tmo_o(rsp_tmo),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
    .wb_sel_o(wb_sel), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_stall_i(wb_stall),
    .dbg_state_o(dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave: stalls s_stall cycles from cycle start, responds s_stall+s_delay cycles in.
  always_comb begin
    s_resp   = wb_cyc && (s_k >= s_stall + s_delay) && (s_mode != M_NOACK);
    wb_stall = wb_cyc && wb_stb && (s_k < s_stall);
    wb_ack   = s_resp && (s_mode != M_ERR);
    wb_err   = s_resp && (s_mode == M_ERR || s_mode == M_BOTH);
    wb_dat_i = (s_mode == M_BADRB && !wb_we) ? rb_val : s_mem[wb_adr[13:2]];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected {err, tmo, data} from the map/bus rules.
  function automatic logic [33:0] model(input logic we, input logic [13:0] addr,
                                        input logic [31:0] data, input int mode);
    int w;
    w = int'(addr[13:2]);
    if (addr[1:0] != 2'b00 || int'(addr) >= 8448) return {2'b10, 32'h0};
    if (mode == M_ERR || mode == M_BOTH) return {2'b10, 32'h0};
    if (mode == M_NOACK) return {2'b11, 32'h0};
    if (!we) return {2'b00, model_mem[w]};
    model_mem[w] = data;
`ifdef DEMO_ALL_WB_MASTER_VERIFY_EN
    if (mode == M_BADRB) return {2'b10, rb_val};
    return {2'b00, data};
`else
    return {2'b00, 32'h0};
`endif
  endfunction

  task automatic issue(input logic we, input logic [13:0] addr, input logic [31:0] data);
    int n;
    cur_we = we; cur_addr = addr; cur_data = data;
    base_cyc = cyc_cnt; base_stb = stb_cnt; base_rd = rd_stb_cnt;
    exp_q.push_back(model(we, addr, data, s_mode));
    issued++;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_data = data;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", 32'(cmd_ready), 1);
    acc_cyc = cyc_no;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (rsp_cnt < issued && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_arrived", rsp_cnt, issued);
  endtask

  task automatic run(input logic we, input logic [13:0] addr, input logic [31:0] data,
                     input int mode, input int stall, input int delay);
    s_mode = mode; s_stall = stall; s_delay = delay;
    issue(we, addr, data);
    wait_rsp();
    step();
  endtask

  initial begin
    logic [33:0] e;
    logic [13:0] a;
    int n, r, md;

    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_data = '0;
    rsp_ready = 1'b1; s_mode = M_OK; s_stall = 0; s_delay = 0; rb_val = '0;
    n_checks = 0; n_errs = 0; cyc_no = 0; cyc_cnt = 0; stb_cnt = 0; rd_stb_cnt = 0;
    rsp_cnt = 0; issued = 0; rise_cyc = 0; acc_cyc = 0; prev_rv = 1'b0;
    cur_addr = '0; cur_data = '0; cur_we = 1'b0; s_k <= 0;
    for (int i = 0; i < 4096; i++) begin
      model_mem[i] = $urandom;
      s_mem[i] <= model_mem[i];
    end

    fork
      forever @(posedge clk) cyc_no++;
      forever begin
        @(posedge clk or posedge rst);
        if (rst) s_k <= 0;
        else begin
          if (!wb_cyc || wb_ack || wb_err) s_k <= 0;
          else s_k <= s_k + 1;
          if (wb_cyc && wb_we && wb_ack && !wb_err) s_mem[wb_adr[13:2]] <= wb_dat_o;
        end
      end
      begin : monitor
        logic [33:0] m;
        forever begin
          @(negedge clk);
          if (wb_cyc) cyc_cnt++;
          if (wb_stb) stb_cnt++;
          if (wb_cyc && wb_stb && !wb_we) rd_stb_cnt++;
          if (wb_cyc && wb_stb) begin
            chk("wb_adr", 32'(wb_adr), 32'(cur_addr));
            chk("wb_sel", 32'(wb_sel), 32'hF);
            if (wb_we) chk("wb_dat", wb_dat_o, cur_data);
`ifdef DEMO_ALL_WB_MASTER_VERIFY_EN
            if (!cur_we) chk("wb_we", 32'(wb_we), 0);
`else
            chk("wb_we", 32'(wb_we), 32'(cur_we));
`endif
          end
          if (rsp_valid && !prev_rv) rise_cyc = cyc_no;
          prev_rv = rsp_valid;
          if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_errs++;
              $display("FAIL rsp_unexpected: got data 0x%0h with empty queue", rsp_data);
            end else begin
              m = exp_q.pop_front();
              chk("rsp_data", rsp_data, m[31:0]);
              chk("rsp_err", 32'(rsp_err), 32'(m[33]));
              chk("rsp_tmo", 32'(rsp_tmo), 32'(m[32]));
            end
            rsp_cnt++;
          end
        end
      end
      begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_rsp", {28'h0, rsp_valid, rsp_err, rsp_tmo, 1'b0}, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_bus", {28'h0, wb_cyc, wb_stb, wb_we, 1'b0}, 0);
    chk("rst_adr", 32'(wb_adr), 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_sel", 32'(wb_sel), 32'hF);
    step();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ready_after_rst", 32'(cmd_ready), 1);
    step();

    // Write 0x123 to 0x4, ack in first bus cycle
    run(1'b1, 14'h4, 32'h123, M_OK, 0, 0);
    chk("wr_latency", rise_cyc - acc_cyc, 3);
`ifndef DEMO_ALL_WB_MASTER_VERIFY_EN
    chk("wr_cyc_cycles", cyc_cnt - base_cyc, 1);
    chk("wr_no_readback", rd_stb_cnt - base_rd, 0);
`endif

    // Read 0x2004 with two stall cycles
    model_mem[12'h801] = 32'hCAFE0001;
    s_mem[12'h801] <= 32'hCAFE0001;
    step();
    run(1'b0, 14'h2004, 32'h0, M_OK, 2, 0);
    chk("stall_stb_cycles", stb_cnt - base_stb, 3);

    // Misaligned and out-of-range reads: no bus cycle
    run(1'b0, 14'h2102, 32'h0, M_OK, 0, 0);
    chk("misaligned_no_cyc", cyc_cnt - base_cyc, 0);
    run(1'b0, 14'h2100, 32'h0, M_OK, 0, 0);
    chk("range_no_cyc", cyc_cnt - base_cyc, 0);
    run(1'b0, 14'h20FC, 32'h0, M_OK, 0, 0);
    chk("last_word_cyc", cyc_cnt - base_cyc, 1);

    // Ack arriving after stb has dropped
    run(1'b0, 14'h100, 32'h0, M_OK, 0, 3);
    chk("late_ack_cyc", cyc_cnt - base_cyc, 4);
    chk("late_ack_stb", stb_cnt - base_stb, 1);

    // Timeout, then a normal command
    run(1'b0, 14'h8, 32'h0, M_NOACK, 0, 0);
    chk("tmo_cyc_cycles", cyc_cnt - base_cyc, 255);
    run(1'b0, 14'h8, 32'h0, M_OK, 1, 1);

    // Ack and err together, plain err on a write
    run(1'b0, 14'h40, 32'h0, M_BOTH, 0, 0);
    run(1'b1, 14'h44, 32'h55AA55AA, M_ERR, 1, 0);

    // Response back-pressure: outputs hold, no new command accepted
    s_mode = M_OK; s_stall = 0; s_delay = 0;
    rsp_ready = 1'b0;
    issue(1'b0, 14'h80, 32'h0);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    e = exp_q[0];
    repeat (5) begin
      chk("hold_valid", 32'(rsp_valid), 1);
      chk("hold_data", rsp_data, e[31:0]);
      chk("hold_err_tmo", {30'h0, rsp_err, rsp_tmo}, {30'h0, e[33:32]});
      chk("hold_cmd_ready", 32'(cmd_ready), 0);
      @(negedge clk);
    end
    step();
    rsp_ready = 1'b1;
    wait_rsp();
    step();

`ifdef DEMO_ALL_WB_MASTER_VERIFY_EN
    // Readback returns a different value than written
    rb_val = 32'h200;
    run(1'b1, 14'h0, 32'h700, M_BADRB, 0, 0);
    chk("verify_readback_seen", 32'(rd_stb_cnt - base_rd > 0), 1);
`endif

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) a = 14'($urandom_range(0, 16383));
      else if (r == 1) a = 14'h20FC;
      else a = 14'($urandom_range(0, 7) * 256 + $urandom_range(0, 3) * 4);
      r = $urandom_range(0, 9);
      md = (r == 7) ? M_ERR : (r == 8) ? M_BOTH : M_OK;
      run(1'($urandom_range(0, 1)), a, $urandom, md, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // Reset during a bus cycle
    s_mode = M_NOACK; s_stall = 0; s_delay = 0;
    issue(1'b0, 14'h10, 32'h0);
    repeat (10) @(negedge clk);
    chk("cyc_before_rst", 32'(wb_cyc), 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_async_cyc_stb", {30'h0, wb_cyc, wb_stb}, 0);
    chk("rst_async_rsp_valid", 32'(rsp_valid), 0);
    exp_q.delete();
    issued = rsp_cnt;
    step();
    step();
    rst = 1'b0;
    step();
    step();
    run(1'b0, 14'h10, 32'h0, M_OK, 0, 0);
    chk("post_rst_cyc", cyc_cnt - base_cyc, 1);

    chk("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
